// File: rtl/board_io_ctrl.sv
// Board-level I/O controller: button sync/debounce, stretched user-design reset, status LEDs.
// Optional heartbeat (counter, led_o[0], hb_tick_o) is built only when BOARD_IO_HEARTBEAT_EN is defined.
module board_io_ctrl #(
  parameter int                 NUM_BTN         = 7,
  parameter int                 NUM_LED         = 8,
  parameter logic [NUM_BTN-1:0] BTN_INVERT      = 7'b0000001,
  parameter int                 BTN_RESET_IDX   = 0,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 RST_HOLD_CYCLES = 16,
  parameter int                 HB_WIDTH        = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  input  logic [NUM_LED-3:0] led_i,
  output logic [NUM_LED-1:0] led_o,
  output logic               design_rst_n_o,
  output logic               hb_tick_o
);

  // state | meaning
  // HOLD  | user design held in reset, rcnt counts released-button cycles
  // RUN   | user design running
  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W = $clog2(RST_HOLD_CYCLES + 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] btn_level_q, btn_level_d;
  logic [NUM_BTN-1:0] btn_press_q, btn_press_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];

  state_t             state_q, state_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic               rst_n_q;
  logic               led_rst_q;
  logic [NUM_LED-3:0] led_user_q;
  logic               led_hb;

  always_comb begin
    btn_level_d = btn_level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if ((sync2_q[i] ^ BTN_INVERT[i]) != btn_level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_level_d[i] = ~btn_level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    btn_press_d = btn_level_d & ~btn_level_q;
  end

  // Sync flops reload the inversion mask so every button reads released after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= BTN_INVERT;
      sync2_q     <= BTN_INVERT;
      btn_level_q <= '0;
      btn_press_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      btn_level_q <= btn_level_d;
      btn_press_q <= btn_press_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_HOLD: begin
        if (btn_level_q[BTN_RESET_IDX]) begin
          rcnt_d = '0;
        end else if (rcnt_q == RCNT_W'(RST_HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (btn_level_q[BTN_RESET_IDX]) begin
          state_d = ST_HOLD;
          rcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      rcnt_q     <= '0;
      rst_n_q    <= 1'b0;
      led_rst_q  <= 1'b1;
      led_user_q <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      rst_n_q    <= (state_d == ST_RUN);
      led_rst_q  <= ~rst_n_q;
      led_user_q <= led_i;
    end
  end

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [HB_WIDTH-1:0] hb_q;
  logic                hb_tick_q;
  logic                led_hb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_q      <= '0;
      hb_tick_q <= 1'b0;
      led_hb_q  <= 1'b0;
    end else begin
      hb_q      <= hb_q + 1'b1;
      hb_tick_q <= &hb_q;
      led_hb_q  <= hb_q[HB_WIDTH-1];
    end
  end

  assign hb_tick_o = hb_tick_q;
  assign led_hb    = led_hb_q;
`else
  assign hb_tick_o = 1'b0;
  assign led_hb    = 1'b0;
`endif

  assign btn_level_o    = btn_level_q;
  assign btn_press_o    = btn_press_q;
  assign design_rst_n_o = rst_n_q;
  assign led_o          = {led_user_q, led_rst_q, led_hb};

endmodule
